// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz VGA timing constants, sync polarity and coordinate width.
// Pixel generators import this package so they agree with vga_sync on the frame geometry.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    // Both sync pins are active-low in this mode.
    localparam logic SYNC_ACTIVE = 1'b0;

    function automatic logic [COORD_W-1:0] to_coord(input int value);
        return COORD_W'(value);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clk pixel enable every CLK_DIV clocks.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // p_tick rises on the edge that wraps div, so the first pulse lands CLK_DIV edges after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            p_tick <= 1'b0;
        end else begin
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
            p_tick <= (div == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// Free-running VGA scan counter with registered, mutually aligned x/y, video_on and sync outputs.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST   = to_coord(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = to_coord(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = to_coord(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS    = to_coord(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_START = to_coord(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = to_coord(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START = to_coord(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = to_coord(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic               video_on_next;
    logic               hsync_next;
    logic               vsync_next;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick)
    );

    // Decode from the next-state position so registered flags line up with the registered x/y.
    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? '0 : y + 1'b1;
            end else begin
                x_next = x + 1'b1;
            end
        end
        video_on_next = (x_next < H_VIS) && (y_next < V_VIS);
        hsync_next    = ((x_next >= HS_START) && (x_next <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next    = ((y_next >= VS_START) && (y_next <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x        <= '0;
            y        <= '0;
            video_on <= 1'b1;
            hsync    <= ~SYNC_ACTIVE;
            vsync    <= ~SYNC_ACTIVE;
        end else begin
            x        <= x_next;
            y        <= y_next;
            video_on <= video_on_next;
            hsync    <= hsync_next;
            vsync    <= vsync_next;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench: lane A runs full 640x480 timing, lane B a shrunken geometry for multi-frame runs.
module tb_vga_sync;

    localparam int A_DIV = 4;
    localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VD = 480, A_VF = 10, A_VS = 2,  A_VB = 33;

    localparam int B_DIV = 2;
    localparam int B_HD = 16, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VD = 8,  B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_FRAME_CLK = (B_HD + B_HF + B_HS + B_HB) * (B_VD + B_VF + B_VS + B_VB) * B_DIV;

    typedef struct {
        logic p_tick;
        int   x;
        int   y;
        logic video_on;
        logic hsync;
        logic vsync;
    } scan_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    logic       p_tick_a, video_on_a, hsync_a, vsync_a;
    logic [9:0] x_a, y_a;
    logic       p_tick_b, video_on_b, hsync_b, vsync_b;
    logic [9:0] x_b, y_b;

    scan_t q_a[$];
    scan_t q_b[$];
    int    cyc_a = 0;
    int    cyc_b = 0;
    int    passed = 0;
    int    total = 0;
    int    refresh_b = 0;
    logic  done_a = 1'b0;
    logic  done_b = 1'b0;

    always #5 clk = ~clk;

    vga_sync dut_a (
        .clk      (clk),
        .reset_n  (rst_a),
        .p_tick   (p_tick_a),
        .x        (x_a),
        .y        (y_a),
        .video_on (video_on_a),
        .hsync    (hsync_a),
        .vsync    (vsync_a)
    );

    vga_sync #(
        .CLK_DIV (B_DIV),
        .H_DISPLAY (B_HD), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_DISPLAY (B_VD), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB)
    ) dut_b (
        .clk      (clk),
        .reset_n  (rst_b),
        .p_tick   (p_tick_b),
        .x        (x_b),
        .y        (y_b),
        .video_on (video_on_b),
        .hsync    (hsync_b),
        .vsync    (vsync_b)
    );

    // Reference: position is just the count of elapsed pixel periods since reset release.
    function automatic scan_t model(input int cyc, input int div,
                                    input int hd, input int hf, input int hs, input int hb,
                                    input int vd, input int vf, input int vs, input int vb);
        scan_t m;
        int ht = hd + hf + hs + hb;
        int vt = vd + vf + vs + vb;
        int n  = (cyc == 0) ? 0 : (cyc - 1) / div;
        m.p_tick   = (cyc > 0) && (cyc % div == 0);
        m.x        = n % ht;
        m.y        = (n / ht) % vt;
        m.video_on = (m.x < hd) && (m.y < vd);
        m.hsync    = !((m.x >= hd + hf) && (m.x < hd + hf + hs));
        m.vsync    = !((m.y >= vd + vf) && (m.y < vd + vf + vs));
        return m;
    endfunction

    task automatic checkOutput(input string name, input scan_t exp_s, input scan_t act);
        total++;
        if (act.p_tick === exp_s.p_tick && act.x == exp_s.x && act.y == exp_s.y &&
            act.video_on === exp_s.video_on && act.hsync === exp_s.hsync && act.vsync === exp_s.vsync) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s t=%0t got tick=%b x=%0d y=%0d von=%b hs=%b vs=%b expected tick=%b x=%0d y=%0d von=%b hs=%b vs=%b",
                     name, $time, act.p_tick, act.x, act.y, act.video_on, act.hsync, act.vsync,
                     exp_s.p_tick, exp_s.x, exp_s.y, exp_s.video_on, exp_s.hsync, exp_s.vsync);
        end
    endtask

    task automatic applyStimulus(input int run_cycles, input int hold_cycles);
        repeat (run_cycles) @(posedge clk);
        #1 rst_b = 1'b0;
        repeat (hold_cycles) @(posedge clk);
        @(negedge clk);
        #1 rst_b = 1'b1;
    endtask

    // Producers push the expected view after every edge; an async reset replaces the pending entry.
    initial begin
        @(posedge clk);
        forever begin
            if (!rst_a) begin
                cyc_a = 0;
                q_a.delete();
            end else begin
                cyc_a++;
            end
            q_a.push_back(model(cyc_a, A_DIV, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB));
            @(posedge clk or negedge rst_a);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            if (!rst_b) begin
                cyc_b = 0;
                q_b.delete();
            end else begin
                cyc_b++;
            end
            q_b.push_back(model(cyc_b, B_DIV, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB));
            @(posedge clk or negedge rst_b);
        end
    end

    // Lane A: release, reset again in the middle of line 0, then run past the first line wrap.
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_a = 1'b1;
        for (int i = 0; i < 2000 && x_a != 10'd300; i++) @(negedge clk);
        @(posedge clk);
        #1 rst_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_a = 1'b1;
        repeat (2 * 800 * A_DIV + 400) @(posedge clk);
        done_a = 1'b1;
    end

    // Lane B: random reset pulses, then a clean three-frame run for the refresh-tick count.
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_b = 1'b1;
        for (int k = 0; k < 5; k++) applyStimulus($urandom_range(30, 700), $urandom_range(1, 4));
        applyStimulus(1, 1);
        repeat (3 * B_FRAME_CLK) @(posedge clk);
        done_b = 1'b1;
    end

    initial begin
        scan_t act;
        @(posedge clk);
        forever begin
            @(negedge clk);
            act = '{p_tick_a, int'(x_a), int'(y_a), video_on_a, hsync_a, vsync_a};
            if (q_a.size() == 0) begin
                total++;
                $display("[TB] FAIL laneA_queue t=%0t got empty expected one entry", $time);
            end else begin
                checkOutput("laneA", q_a.pop_front(), act);
            end
            act = '{p_tick_b, int'(x_b), int'(y_b), video_on_b, hsync_b, vsync_b};
            if (q_b.size() == 0) begin
                total++;
                $display("[TB] FAIL laneB_queue t=%0t got empty expected one entry", $time);
            end else begin
                checkOutput("laneB", q_b.pop_front(), act);
            end
            if (!rst_b) refresh_b = 0;
            else if (!done_b && p_tick_b && x_b == 10'd0 && y_b == 10'(B_VD + 1)) refresh_b++;
            if (done_a && done_b) break;
        end
        total++;
        if (refresh_b == 3) passed++;
        else $display("[TB] FAIL refresh_count got %0d expected 3", refresh_b);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
